// File: rtl/pcie_wr_dma_scheduler.sv
// Write-DMA scheduler: splits one host descriptor into MWr TLP commands bounded by MPS and 4 KB,
// releasing each only once its data beats are present in the FIFO and not already claimed.
module pcie_wr_dma_scheduler #(
    parameter int MAX_MPS_BYTES = 256,
    parameter int LEVEL_W       = 10
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [63:0]        cfg_addr,
    input  logic [31:0]        cfg_len,
    input  logic [2:0]         cfg_mps_sel,
    input  logic               cfg_start,
    input  logic               cfg_abort,
    input  logic [LEVEL_W-1:0] fifo_level,
    input  logic               fifo_pop,
    output logic               cmd_valid,
    input  logic               cmd_ready,
    output logic [63:0]        cmd_addr,
    output logic [9:0]         cmd_len_dw,
    output logic               cmd_4dw,
    output logic               cmd_last,
    output logic               stat_busy,
    output logic               stat_aborted,
    output logic [15:0]        stat_tlp_cnt,
    output logic               irq_done
);
    typedef enum logic [2:0] {IDLE, CALC, WAIT_DATA, ISSUE, DONE} state_t;

    localparam logic [31:0] MAX_MPS = 32'(MAX_MPS_BYTES);

    state_t             state_q, state_d;
    logic [63:0]        addr_q, addr_d;
    logic [31:0]        rem_q, rem_d;
    logic [12:0]        tlp_bytes_q, tlp_bytes_d;
    logic [LEVEL_W-1:0] beats_q, beats_d;
    logic [LEVEL_W-1:0] reserved_q, reserved_d;
    logic               last_q, last_d;
    logic               abort_pend_q, abort_pend_d;
    logic               busy_q, busy_d;
    logic               aborted_q, aborted_d;
    logic [15:0]        tlp_cnt_q, tlp_cnt_d;

    logic [31:0]        mps_dec, eff_mps, bnd_bytes, calc_bytes;
    logic [LEVEL_W-1:0] calc_beats, need_beats, res_sum;
    logic [LEVEL_W:0]   avail;
    logic               data_ok, hs;
    logic               unused_lsbs;

    assign unused_lsbs = ^{cfg_addr[4:0], cfg_len[4:0]};

    // CALC checks data with the freshly computed size so a ready FIFO skips WAIT_DATA entirely.
    always_comb begin
        case (cfg_mps_sel)
            3'd1:    mps_dec = 32'd256;
            3'd2:    mps_dec = 32'd512;
            default: mps_dec = 32'd128;
        endcase
        eff_mps    = (mps_dec > MAX_MPS) ? MAX_MPS : mps_dec;
        bnd_bytes  = 32'h1000 - {20'd0, addr_q[11:0]};
        calc_bytes = rem_q;
        if (eff_mps < calc_bytes)   calc_bytes = eff_mps;
        if (bnd_bytes < calc_bytes) calc_bytes = bnd_bytes;
        calc_beats = LEVEL_W'(calc_bytes >> 5);
        need_beats = (state_q == CALC) ? calc_beats : beats_q;
        avail      = {1'b0, fifo_level} - {1'b0, reserved_q};
        data_ok    = !avail[LEVEL_W] && (avail[LEVEL_W-1:0] >= need_beats);
        hs         = (state_q == ISSUE) && cmd_ready;
    end

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        rem_d        = rem_q;
        tlp_bytes_d  = tlp_bytes_q;
        beats_d      = beats_q;
        last_d       = last_q;
        abort_pend_d = abort_pend_q;
        busy_d       = busy_q;
        aborted_d    = aborted_q;
        tlp_cnt_d    = tlp_cnt_q;
        case (state_q)
            IDLE: begin
                if (cfg_start) begin
                    addr_d       = {cfg_addr[63:5], 5'd0};
                    rem_d        = {cfg_len[31:5], 5'd0};
                    tlp_cnt_d    = 16'd0;
                    aborted_d    = 1'b0;
                    abort_pend_d = 1'b0;
                    busy_d       = 1'b1;
                    state_d      = (cfg_len[31:5] == 27'd0) ? DONE : CALC;
                end
            end
            CALC: begin
                tlp_bytes_d = calc_bytes[12:0];
                beats_d     = calc_beats;
                last_d      = (rem_q == calc_bytes);
                if (cfg_abort) begin
                    aborted_d = 1'b1;
                    state_d   = DONE;
                end else begin
                    state_d = data_ok ? ISSUE : WAIT_DATA;
                end
            end
            WAIT_DATA: begin
                if (cfg_abort) begin
                    aborted_d = 1'b1;
                    state_d   = DONE;
                end else if (data_ok) begin
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                // An abort here must let the offered command finish its handshake first.
                if (cfg_abort) abort_pend_d = 1'b1;
                if (hs) begin
                    addr_d    = addr_q + {51'd0, tlp_bytes_q};
                    rem_d     = rem_q - {19'd0, tlp_bytes_q};
                    tlp_cnt_d = (tlp_cnt_q != 16'hFFFF) ? tlp_cnt_q + 16'd1 : tlp_cnt_q;
                    if (cfg_abort || abort_pend_q) begin
                        aborted_d = 1'b1;
                        state_d   = DONE;
                    end else begin
                        state_d = last_q ? DONE : CALC;
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (state_d == DONE) busy_d = 1'b0;
    end

    // Reservations survive DONE so beats already promised to the packer keep draining.
    always_comb begin
        res_sum    = reserved_q + (hs ? beats_q : '0);
        reserved_d = (fifo_pop && (res_sum != '0)) ? res_sum - 1'b1 : res_sum;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= IDLE;
            addr_q       <= '0;
            rem_q        <= '0;
            tlp_bytes_q  <= '0;
            beats_q      <= '0;
            reserved_q   <= '0;
            last_q       <= 1'b0;
            abort_pend_q <= 1'b0;
            busy_q       <= 1'b0;
            aborted_q    <= 1'b0;
            tlp_cnt_q    <= '0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            rem_q        <= rem_d;
            tlp_bytes_q  <= tlp_bytes_d;
            beats_q      <= beats_d;
            reserved_q   <= reserved_d;
            last_q       <= last_d;
            abort_pend_q <= abort_pend_d;
            busy_q       <= busy_d;
            aborted_q    <= aborted_d;
            tlp_cnt_q    <= tlp_cnt_d;
        end
    end

    assign cmd_valid    = (state_q == ISSUE);
    assign cmd_addr     = addr_q;
    assign cmd_len_dw   = tlp_bytes_q[11:2];
    assign cmd_4dw      = |addr_q[63:32];
    assign cmd_last     = last_q;
    assign stat_busy    = busy_q;
    assign stat_aborted = aborted_q;
    assign stat_tlp_cnt = tlp_cnt_q;
    assign irq_done     = (state_q == DONE);
endmodule
